// File: rtl/subtrator_pkg.sv
// Shared types and sizing helpers for the time-multiplexed carry-bypass subtractor.
package subtrator_pkg;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/bypass8_sub.sv
// Combinational 8-bit A + ~B + Cin slice; carry skips the ripple chain when every bit propagates.
module bypass8_sub
  import subtrator_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               Cin,
  output logic [SLICE_W-1:0] S,
  output logic               Cout
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic               ripple_c;

  always_comb begin
    p        = A ^ ~B;
    g        = A & ~B;
    ripple_c = Cin;
    S        = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      S[i]     = p[i] ^ ripple_c;
      ripple_c = g[i] | (p[i] & ripple_c);
    end
    // Full group propagate means carry-out equals carry-in, so skip the ripple result.
    Cout = (&p) ? Cin : ripple_c;
  end

endmodule

// File: rtl/subtrator_bypass8_32bits.sv
// D = A - B - Bin, one 8-bit slice per clock; result valid WIDTH/8 cycles after accept.
// in_ready only in IDLE; results held in DONE until out_ready, in_valid ignored meanwhile.
module subtrator_bypass8_32bits
  import subtrator_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Z,
  output logic             V
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH == 0) begin : g_width_chk
      $error("WIDTH must be a nonzero multiple of 8");
    end
  endgenerate

  state_t                          state_q;
  logic [NSLICE-1:0][SLICE_W-1:0]  a_q;
  logic [NSLICE-1:0][SLICE_W-1:0]  b_q;
  logic [NSLICE-1:0][SLICE_W-1:0]  d_q;
  logic [NSLICE-1:0][SLICE_W-1:0]  d_d;
  logic                            carry_q;
  logic [IDX_W-1:0]                idx_q;
  logic                            bout_q;
  logic                            z_q;
  logic                            v_q;
  logic                            out_valid_q;

  logic [SLICE_W-1:0]              slice_s;
  logic                            slice_c;

  bypass8_sub u_slice (
    .A    (a_q[idx_q]),
    .B    (b_q[idx_q]),
    .Cin  (carry_q),
    .S    (slice_s),
    .Cout (slice_c)
  );

  // Difference as it will look once the current slice is written; feeds the Z/V flags.
  always_comb begin
    d_d        = d_q;
    d_d[idx_q] = slice_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      bout_q      <= 1'b0;
      z_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= ~Bin;
            idx_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          d_q     <= d_d;
          carry_q <= slice_c;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            bout_q      <= ~slice_c;
            z_q         <= (d_d == '0);
            v_q         <= (a_q[NSLICE-1][SLICE_W-1] != b_q[NSLICE-1][SLICE_W-1]) &&
                           (d_d[NSLICE-1][SLICE_W-1] != a_q[NSLICE-1][SLICE_W-1]);
            out_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign Bout      = bout_q;
  assign Z         = z_q;
  assign V         = v_q;

endmodule

// File: doc/subtrator_bypass8_32bits.md
# subtrator_bypass8_32bits

Multi-cycle 32-bit subtractor computing D = A − B − Bin, one 8-bit carry-bypass slice per clock, with a valid/ready handshake on both sides. It is the subtraction counterpart to the team's 32-bit carry-bypass adders. It reuses the same 8-bit bypass slice structure but time-multiplexes a single slice, for area-constrained datapaths that can tolerate latency.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 8 (elaboration-time assertion).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  minuend.
- B  in  WIDTH  subtrahend.
- Bin  in  1  borrow in.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- D  out  WIDTH  difference.
- Bout  out  1  borrow out.
- Z  out  1  D == 0.
- V  out  1  signed (two's-complement) overflow.

## Operation
- FSM states are IDLE, CALC and DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - in_valid&&in_ready at a rising edge latches A, B and Bin into internal registers, sets carry=~Bin and idx=0, and moves to CALC.
- **CALC**
  - in_ready=0.
  - Each edge computes slice idx: {c_out, s} = A[idx] + ~B[idx] + carry.
  - Writes s into D[idx*8+:8], sets carry=c_out and increments idx.
  - At idx=NSLICE−1 (NSLICE=WIDTH/8) the edge also registers the flags and moves to DONE:
    - Bout = ~c_out.
    - Z = (final D == 0).
    - V = (A[msb]≠B[msb]) && (D[msb]≠A[msb]).
- **DONE**
  - out_valid=1.
  - D, Bout, Z and V are held stable until out_ready=1 at an edge, which moves the FSM to IDLE.
  - in_valid is ignored in DONE.
- **Slice arithmetic**
  - The slice forms per-bit propagate P = A^~B and a group propagate &P.
  - When the group propagate is 1, c_out = carry_in (bypass); otherwise c_out comes from the ripple chain.
  - The result is bit-identical to plain subtraction.
- Inputs are sampled only at the accept edge; A, B and Bin may change afterwards.
- **Reset values:** state=IDLE, D=0, Bout=0, Z=0, V=0, out_valid=0, idx=0. in_ready=1 as soon as rst_n is released.
- **Reset mid-operation** (CALC or DONE):
  - Aborts the operation; no out_valid is produced.
  - All outputs return to reset values immediately, without waiting for a clock edge.

## Timing
- Accept at edge 0 → slices computed at edges 1..NSLICE → out_valid high after edge NSLICE. This is 4 cycles for WIDTH=32.
- With out_ready tied high:
  - DONE lasts exactly 1 cycle; IDLE is re-entered at edge NSLICE+1.
  - The next accept is possible at edge NSLICE+2.
  - Sustained throughput is one operation per NSLICE+2 cycles.
- in_ready is a combinational decode of state. out_valid and all result outputs are registered.
- D holds partially written slices during CALC. Its value is meaningful only while out_valid=1.
- The critical path is one 8-bit slice plus the carry register; it is independent of WIDTH.

## Structure
- **Package subtrator_pkg:**
  - SLICE_W = 8.
  - State enum typedef {IDLE, CALC, DONE}.
  - Function computing NSLICE from WIDTH.
- **Sub-module bypass8_sub:** combinational 8-bit A + ~B + cin slice with group-propagate bypass. Ports: A[7:0], B[7:0], Cin, S[7:0], Cout; B is inverted internally.
- **Top level:** FSM, operand registers, idx counter (clog2(NSLICE) bits), carry register, result and flag registers.

## Test plan
- A=0x0000_0005, B=0x0000_0003, Bin=0 → D=0x0000_0002, Bout=0, Z=0, V=0; out_valid rises exactly 4 cycles after accept.
- A=0x0000_0000, B=0x0000_0001, Bin=0 → D=0xFFFF_FFFF, Bout=1, V=0; slices 1..3 take the bypass path.
- A=0x8000_0000, B=0x0000_0001, Bin=0 → D=0x7FFF_FFFF, V=1, Bout=0, Z=0.
- Equal operands 0x1234_5678:
  - Bin=0 → D=0, Z=1, Bout=0.
  - Bin=1 → D=0xFFFF_FFFF, Z=0, Bout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands → D and flags are unchanged, in_ready=0, new operands are not taken. After out_ready=1, the next accept occurs 1 cycle after IDLE is entered.
- Reset pulse while in CALC after 2 slices → out_valid=0, D=0 and in_ready=1 immediately. The following operation (A=100, B=58) yields D=42 with normal latency.
